// File: rtl/mandelbrot_pkg.sv
// Shared constants and scan state type for the Mandelbrot raster sequencer.
// Complex-plane values are signed Q4.28.
package mandelbrot_pkg;

  localparam int H_RES   = 800;
  localparam int V_RES   = 600;
  localparam int X_STEP  = 4;
  localparam int COORD_W = 16;
  localparam int FIX_W   = 32;

  localparam logic [FIX_W-1:0] C_RE_START = 32'hD800_0000;
  localparam logic [FIX_W-1:0] C_IM_START = 32'h1500_0000;
  localparam logic [FIX_W-1:0] D_RE       = 32'h0047_AE14;
  localparam logic [FIX_W-1:0] D_IM       = 32'h0011_EB85;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_axis_acc.sv
// One scan axis: a coordinate counter with terminal-count flag plus the paired
// fixed-point accumulator. A step at terminal count reloads both start values.
module scan_axis_acc #(
  parameter int               CNT_W     = 16,
  parameter int               FIX_W     = 32,
  parameter int               LAST      = 796,
  parameter int               STEP      = 4,
  parameter logic [FIX_W-1:0] ACC_INIT  = '0,
  parameter logic [FIX_W-1:0] ACC_DELTA = '0,
  parameter bit               ACC_SUB   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_cnt,
  output logic [FIX_W-1:0] o_acc,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FIX_W-1:0] acc_q, acc_d;
  logic             tc;

  assign tc = (cnt_q == CNT_W'(LAST));

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (i_load || (i_step && tc)) begin
      cnt_d = '0;
      acc_d = ACC_INIT;
    end else if (i_step) begin
      cnt_d = cnt_q + CNT_W'(STEP);
      // Two's-complement wrap is intended; defaults stay in range.
      acc_d = ACC_SUB ? (acc_q - ACC_DELTA) : (acc_q + ACC_DELTA);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      acc_q <= ACC_INIT;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_acc = acc_q;
  assign o_tc  = tc;

endmodule

// File: rtl/mandelbrot_scan_gen.sv
// Raster point sequencer: walks column-groups x rows, emitting (x, y, c) per
// valid/ready beat. All outputs come straight from flops.
module mandelbrot_scan_gen
  import mandelbrot_pkg::*;
#(
  parameter int SCAN_H = mandelbrot_pkg::H_RES,
  parameter int SCAN_V = mandelbrot_pkg::V_RES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [FIX_W-1:0]   o_c_re,
  output logic [FIX_W-1:0]   o_c_im,
  output logic               o_busy,
  output logic               o_done
);

  scan_state_e state_q, state_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        load, x_step, y_step;
  logic        x_tc, y_tc, hs;

  assign hs = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    x_step  = 1'b0;
    y_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        // Abort beats a same-cycle handshake, and never signals done.
        if (i_abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (hs) begin
          if (x_tc && y_tc) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_step = 1'b1;
            y_step = x_tc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  scan_axis_acc #(
    .CNT_W(COORD_W), .FIX_W(FIX_W), .LAST(SCAN_H - X_STEP), .STEP(X_STEP),
    .ACC_INIT(C_RE_START), .ACC_DELTA(D_RE), .ACC_SUB(1'b0)
  ) u_x_axis (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(load), .i_step(x_step),
    .o_cnt(o_x), .o_acc(o_c_re), .o_tc(x_tc)
  );

  scan_axis_acc #(
    .CNT_W(COORD_W), .FIX_W(FIX_W), .LAST(SCAN_V - 1), .STEP(1),
    .ACC_INIT(C_IM_START), .ACC_DELTA(D_IM), .ACC_SUB(1'b1)
  ) u_y_axis (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(load), .i_step(y_step),
    .o_cnt(o_y), .o_acc(o_c_im), .o_tc(y_tc)
  );

  assign o_valid = valid_q;
  assign o_busy  = (state_q == RUN);
  assign o_done  = done_q;

endmodule

// File: tb/tb_mandelbrot_scan_gen.sv
// Randomized-stall bench for mandelbrot_scan_gen; expected points come from a
// closed-form beat-index model. Frame height is shortened to keep runs short.
module tb_mandelbrot_scan_gen;
  import mandelbrot_pkg::*;

  localparam int VR    = 40;
  localparam int COLS  = H_RES / X_STEP;
  localparam int FRAME = COLS * VR;

  logic               clk = 1'b0;
  logic               rst_n, start, abort, ready;
  logic               o_valid, o_busy, o_done;
  logic [COORD_W-1:0] o_x, o_y;
  logic [FIX_W-1:0]   o_c_re, o_c_im;
  int                 n_assert = 0;
  int                 n_fail   = 0;

  always #5 clk = ~clk;

  mandelbrot_scan_gen #(.SCAN_H(H_RES), .SCAN_V(VR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_ready(ready), .o_valid(o_valid), .o_x(o_x), .o_y(o_y),
    .o_c_re(o_c_re), .o_c_im(o_c_im), .o_busy(o_busy), .o_done(o_done)
  );

  wire [95:0] pt   = {o_x, o_y, o_c_re, o_c_im};
  wire [95:0] stat = {93'b0, o_valid, o_busy, o_done};

  // Point n of the raster, straight from column/row arithmetic.
  function automatic logic [95:0] exp_pt(input int n);
    int          col, row;
    logic [31:0] re, im;
    col = n % COLS;
    row = n / COLS;
    re  = C_RE_START + 32'(col) * D_RE;
    im  = C_IM_START - 32'(row) * D_IM;
    return {16'(col * X_STEP), 16'(row), re, im};
  endfunction

  function automatic logic [95:0] st(input bit v, input bit b, input bit d);
    return {93'b0, v, b, d};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stat"}, stat, st(0, 0, 0));
    chk({tag, "_pt"}, pt, {16'd0, 16'd0, C_RE_START, C_IM_START});
  endtask

  task automatic pulse_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Called at the negedge after start was taken; walks until done/abort/reset.
  task automatic run_frame(input bit stall, input int abort_at, input int start_at,
                           input int rst_at);
    int beats = 0;
    int cyc   = 0;
    bit hs, ab;
    while (cyc < 60000) begin
      cyc++;
      chk("run_stat", stat, st(1, 1, 0));
      chk("point", pt, exp_pt(beats));
      if (beats == 1)
        chk("beat1", pt, {16'd4, 16'd0, 32'hD847AE14, 32'h15000000});
      if (beats == COLS)
        chk("rowwrap", pt, {16'd0, 16'd1, 32'hD8000000, 32'h14EE147B});
      ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      ab    = (beats == abort_at);
      abort = ab;
      if (ab) ready = 1'b1;
      start = (beats == start_at);
      if (beats == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      hs = ready;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (ab) begin
        chk("abort_stat", stat, st(0, 0, 0));
        return;
      end
      if (hs) beats++;
      if (beats == FRAME) begin
        chk("done_stat", stat, st(0, 0, 1));
        chk("last_pt", pt, exp_pt(FRAME - 1));
        @(negedge clk);
        chk("post_done", stat, st(0, 0, 0));
        return;
      end
    end
    chk("timeout", 96'(cyc), 96'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    #12 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort", stat, st(0, 0, 0));

    // Full frame, always ready.
    pulse_start(1'b0);
    run_frame(1'b0, -1, -1, -1);

    // Full frame, random stalls, stray start mid-run.
    pulse_start(1'b0);
    run_frame(1'b1, -1, 100, -1);

    // Abort mid-frame.
    pulse_start(1'b0);
    run_frame(1'b0, 5000, -1, -1);
    @(negedge clk);
    chk("abort_quiet", stat, st(0, 0, 0));

    // Start together with abort in idle: start wins; then async reset mid-scan.
    pulse_start(1'b1);
    run_frame(1'b0, -1, -1, 300);
    @(negedge clk);
    chk_reset("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
